// File: rtl/vend_pkg.sv
// vend_pkg: state encoding, segment lookup and total limit for vend_ctrl (S_REFUND exists only with VEND_REFUND_EN)
package vend_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_PAY,
    S_CHANGE
`ifdef VEND_REFUND_EN
    , S_REFUND
`endif
  } state_t;
  localparam logic [19:0] TOTAL_MAX = 20'd999_999;
  localparam logic [9:0][6:0] SEG_LUT = {7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
endpackage

// File: rtl/vend_bin2bcd.sv
// vend_bin2bcd: iterative shift-add-3 conversion of a 20-bit value to six BCD digits, result valid while done
module vend_bin2bcd (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [19:0] bin,
  output logic        busy,
  output logic        done,
  output logic [23:0] bcd
);
  logic [43:0] sh, adj;
  logic [4:0] cnt;
  always_comb begin
    adj = sh;
    for (int d = 0; d < 6; d++)
      adj[20+4*d +: 4] = adj[20+4*d +: 4] > 4'd4 ? adj[20+4*d +: 4] + 4'd3 : adj[20+4*d +: 4];
  end
  assign bcd = sh[43:20];
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      sh   <= '0;
      cnt  <= '0;
    end else begin
      done <= busy && cnt == 5'd19;
      if (start && !busy) begin
        sh   <= {24'd0, bin};
        cnt  <= '0;
        busy <= 1'b1;
      end else if (busy) begin
        sh   <= adj << 1;
        cnt  <= cnt + 5'd1;
        busy <= cnt != 5'd19;
      end
    end
  end
endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: vending controller with coin accounting and 6-digit scanned display; define VEND_REFUND_EN for cancel-refund in PAY
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int                     NUM_ITEMS  = 4,
  parameter logic [8*NUM_ITEMS-1:0] PRICE_LIST = {8'd25, 8'd20, 8'd15, 8'd10},
  parameter int                     COIN_A     = 5,
  parameter int                     COIN_B     = 20,
  parameter int                     TOTAL_INIT = 200,
  parameter int                     CHANGE_CYC = 100_000_000,
  parameter int                     SCAN_DIV   = 50_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_ITEMS-1:0] key_sel,
  input  logic                 key_ok,
  input  logic                 key_cancel,
  input  logic                 coin_a,
  input  logic                 coin_b,
  output logic                 vend,
  output logic [1:0]           vend_item,
  output logic                 change_busy,
  output logic [7:0]           change_amt,
  output logic [5:0]           sel,
  output logic [7:0]           seg
);
  state_t state, state_n;
  logic [1:0] item, key_idx;
  logic key_hit, paid_ok, hold_done, dp_n, conv_start, conv_busy, conv_done;
  logic [7:0] price, paid, item_price;
  logic [9:0] paid_sum;
  logic [19:0] total, disp_val, last_val;
  logic [20:0] total_sum;
  logic [31:0] hold_cnt, scan_cnt;
  logic [23:0] conv_bcd, bcd;
  logic [3:0] digit;
  assign key_hit    = |key_sel;
  assign item_price = PRICE_LIST[8*(NUM_ITEMS-1-int'(item)) +: 8];
  assign paid_sum   = 10'(paid) + (coin_a ? 10'(COIN_A) : 10'd0) + (coin_b ? 10'(COIN_B) : 10'd0);
  assign paid_ok    = paid >= price;
  assign hold_done  = hold_cnt == 32'(CHANGE_CYC - 1);
  assign total_sum  = 21'(total) + 21'(price);
  assign vend_item  = item;
`ifdef VEND_REFUND_EN
  assign change_busy = state == S_CHANGE || state == S_REFUND;
  assign dp_n        = !(state == S_REFUND && !sel[5]);
`else
  assign change_busy = state == S_CHANGE;
  assign dp_n        = 1'b1;
`endif
  assign disp_val = change_busy ? 20'(change_amt) :
                    state == S_PAY ? 20'(paid_ok ? 8'd0 : price - paid) :
                    state == S_SELECT ? 20'(item_price) : total;
  assign conv_start = !conv_busy && disp_val != last_val;
  always_comb begin
    key_idx = 2'd0;
    for (int i = NUM_ITEMS - 1; i >= 0; i--)
      if (key_sel[i]) key_idx = 2'(i);
  end
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   state_n = key_hit ? S_SELECT : S_IDLE;
      S_SELECT: state_n = key_cancel ? S_IDLE : key_ok ? S_PAY : S_SELECT;
`ifdef VEND_REFUND_EN
      S_PAY:    state_n = paid_ok ? S_CHANGE : key_cancel ? S_REFUND : S_PAY;
      S_REFUND: state_n = hold_done ? S_IDLE : S_REFUND;
`else
      S_PAY:    state_n = paid_ok ? S_CHANGE : S_PAY;
`endif
      S_CHANGE: state_n = hold_done ? S_IDLE : S_CHANGE;
      default:  state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      total      <= 20'(TOTAL_INIT);
      paid       <= '0;
      price      <= '0;
      item       <= '0;
      vend       <= 1'b0;
      change_amt <= '0;
      hold_cnt   <= '0;
    end else begin
      state <= state_n;
      vend  <= state == S_PAY && paid_ok;
      if (state_n == S_SELECT && key_hit) item <= key_idx;
      if (state == S_SELECT && state_n == S_PAY) price <= item_price;
      if (state == S_PAY && state_n == S_PAY) paid <= paid_sum > 10'd255 ? 8'd255 : paid_sum[7:0];
      if (state == S_PAY && paid_ok) change_amt <= paid - price;
`ifdef VEND_REFUND_EN
      if (state == S_PAY && state_n == S_REFUND) change_amt <= paid;
`endif
      if (change_busy) hold_cnt <= hold_done ? 32'd0 : hold_cnt + 32'd1;
      if (state == S_CHANGE && hold_done) total <= total_sum > 21'(TOTAL_MAX) ? TOTAL_MAX : total_sum[19:0];
      if (change_busy && hold_done) begin
        paid       <= '0;
        price      <= '0;
        change_amt <= '0;
      end
    end
  end
  vend_bin2bcd u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (disp_val),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      last_val <= '0;
      bcd      <= '0;
    end else begin
      if (conv_start) last_val <= disp_val;
      if (conv_done) bcd <= conv_bcd;
    end
  end
  always_comb begin
    digit = 4'd0;
    for (int i = 0; i < 6; i++)
      if (!sel[i]) digit = bcd[4*i +: 4];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sel      <= 6'b011111;
      seg      <= 8'hFF;
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt == 32'(SCAN_DIV - 1) ? 32'd0 : scan_cnt + 32'd1;
      if (scan_cnt == 32'(SCAN_DIV - 1)) sel <= {sel[0], sel[5:1]};
      seg <= {dp_n, SEG_LUT[digit]};
    end
  end
endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: randomized transactions checked against a transaction-level model of vend_ctrl
module tb_vend_ctrl;
  localparam int SCAN = 4;
  localparam int CHG  = 120;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] key_sel = '0;
  logic key_ok = 1'b0, key_cancel = 1'b0, coin_a = 1'b0, coin_b = 1'b0;
  logic vend, vend_s, busy, busy_s;
  logic [1:0] vend_item, vend_item_s;
  logic [7:0] change_amt, change_amt_s, seg, seg_s;
  logic [5:0] sel, sel_s;
  int n_chk = 0, n_err = 0;
  int m_total = 200, m_total_s = 999_990, m_vends = 0;
  int vend_seen = 0, vend_seen_s = 0, run = 0, last_run = 0;
  int prices[4] = '{25, 20, 15, 10};
  int seg_hi[10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};
  always #5 clk = ~clk;
  vend_ctrl #(.CHANGE_CYC(CHG), .SCAN_DIV(SCAN)) dut (
    .clk(clk), .rst(rst), .key_sel(key_sel), .key_ok(key_ok), .key_cancel(key_cancel),
    .coin_a(coin_a), .coin_b(coin_b), .vend(vend), .vend_item(vend_item),
    .change_busy(busy), .change_amt(change_amt), .sel(sel), .seg(seg)
  );
  vend_ctrl #(.TOTAL_INIT(999_990), .CHANGE_CYC(CHG), .SCAN_DIV(SCAN)) u_sat (
    .clk(clk), .rst(rst), .key_sel(key_sel), .key_ok(key_ok), .key_cancel(key_cancel),
    .coin_a(coin_a), .coin_b(coin_b), .vend(vend_s), .vend_item(vend_item_s),
    .change_busy(busy_s), .change_amt(change_amt_s), .sel(sel_s), .seg(seg_s)
  );
  always @(negedge clk) begin
    if (vend) vend_seen++;
    if (vend_s) vend_seen_s++;
    if (busy) run++;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic pulse(input int w, input logic [3:0] m);
    case (w)
      0: key_sel = m;
      1: key_ok = 1'b1;
      2: key_cancel = 1'b1;
      default: begin
        coin_a = m[0];
        coin_b = m[1];
      end
    endcase
    tick();
    key_sel = '0;
    key_ok = 1'b0;
    key_cancel = 1'b0;
    coin_a = 1'b0;
    coin_b = 1'b0;
  endtask
  function automatic int lowest(input logic [3:0] m);
    int r = 0;
    for (int i = 3; i >= 0; i--) if (m[i]) r = i;
    return r;
  endfunction
  function automatic logic [7:0] seg_of(input int v, input int p, input bit dp_left);
    int q = v;
    logic [7:0] t;
    for (int k = 0; k < 5 - p; k++) q = q / 10;
    t = 8'(seg_hi[q % 10]);
    return {!(dp_left && p == 0), ~t[6:0]};
  endfunction
  task automatic check_disp(input string tag, input int v, input int vs, input bit dp_left);
    logic [47:0] got, gots, exp, exps;
    logic [5:0] pat;
    int w;
    repeat (30) tick();
    for (int p = 0; p < 6; p++) begin
      pat = ~(6'b100000 >> p);
      w = 0;
      while ((sel !== pat || sel_s !== pat) && w < 8 * SCAN) begin
        tick();
        w++;
      end
      tick();
      got[47-8*p -: 8]  = seg;
      gots[47-8*p -: 8] = seg_s;
      exp[47-8*p -: 8]  = seg_of(v, p, dp_left);
      exps[47-8*p -: 8] = seg_of(vs, p, dp_left);
    end
    chk(tag, 64'(got), 64'(exp));
    chk({tag, "_sat"}, 64'(gots), 64'(exps));
  endtask
  task automatic wait_idle(input string tag);
    int w = 0;
    while (busy && w < CHG + 20) begin
      tick();
      w++;
    end
    tick();
    chk({tag, "_busy_len"}, 64'(last_run), 64'(CHG));
  endtask
  task automatic txn(input logic [3:0] m1, input logic [3:0] m2, input int mode, input int n_before, input logic [31:0] coins);
    int item, price, paid, k, w;
    logic [1:0] c;
    pulse(0, m1);
    item = lowest(m1);
    if (m2 != 0) begin
      pulse(0, m2);
      item = lowest(m2);
    end
    price = prices[item];
    check_disp("select_price", price, price, 1'b0);
    if (mode == 1) begin
      pulse(2, '0);
      check_disp("cancel_idle", m_total, m_total_s, 1'b0);
      return;
    end
    pulse(1, '0);
    paid = 0;
    k = 0;
    while (paid < price) begin
      if (mode == 2 && k == n_before) begin
        pulse(2, '0);
`ifdef VEND_REFUND_EN
        chk("refund_busy", 64'(busy), 64'(1));
        chk("refund_amt", 64'(change_amt), 64'(paid));
        chk("refund_amt_sat", 64'(change_amt_s), 64'(paid));
        check_disp("refund_disp", paid, paid, 1'b1);
        wait_idle("refund");
        check_disp("refund_idle", m_total, m_total_s, 1'b0);
        return;
`endif
      end
      c = coins[2*k +: 2];
      if (c == 2'b00) c = 2'($urandom_range(1, 3));
      pulse(3, {2'b00, c});
      paid = paid + (c[0] ? 5 : 0) + (c[1] ? 20 : 0);
      if (paid > 255) paid = 255;
      k++;
      if (paid < price && k == 1) check_disp("remaining", price - paid, price - paid, 1'b0);
    end
    w = 0;
    while (!vend && w < 5) begin
      tick();
      w++;
    end
    chk("vend_pulse", 64'(vend), 64'(1));
    chk("vend_item", 64'(vend_item), 64'(item));
    chk("vend_item_sat", 64'(vend_item_s), 64'(item));
    chk("change_amt", 64'(change_amt), 64'(paid - price));
    chk("change_amt_sat", 64'(change_amt_s), 64'(paid - price));
    chk("change_busy_sat", 64'(busy_s), 64'(1));
    m_vends++;
    check_disp("change_disp", paid - price, paid - price, 1'b0);
    wait_idle("change");
    m_total   = (m_total + price > 999_999) ? 999_999 : m_total + price;
    m_total_s = (m_total_s + price > 999_999) ? 999_999 : m_total_s + price;
    check_disp("idle_total", m_total, m_total_s, 1'b0);
  endtask
  initial begin
    int w, mode;
    logic [3:0] m2;
    repeat (3) tick();
    chk("rst_sel", 64'(sel), 64'(6'b011111));
    chk("rst_seg", 64'(seg), 64'(8'hFF));
    chk("rst_vend", 64'(vend), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_change_amt", 64'(change_amt), 64'(0));
    rst = 1'b0;
    w = 0;
    while (sel === 6'b011111 && w < 4 * SCAN) begin
      tick();
      w++;
    end
    chk("scan_period", 64'(w), 64'(SCAN));
    chk("scan_step", 64'(sel), 64'(6'b101111));
    check_disp("reset_total", m_total, m_total_s, 1'b0);
    txn(4'b0100, '0, 0, 0, 32'h15);
    txn(4'b0001, '0, 0, 0, 32'h0A);
    txn(4'b0001, '0, 0, 0, 32'h03);
    txn(4'b0010, '0, 2, 1, 32'h01);
    txn(4'b1110, 4'b1000, 1, 0, 32'h0);
    for (int n = 0; n < 20; n++) begin
      m2 = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
      mode = $urandom_range(0, 3);
      txn(4'($urandom_range(1, 15)), m2, mode == 3 ? 0 : mode, $urandom_range(0, 2), 32'h0);
    end
    pulse(0, 4'b0001);
    pulse(1, '0);
    pulse(3, 4'b0001);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    m_total = 200;
    m_total_s = 999_990;
    check_disp("rst_mid_txn", m_total, m_total_s, 1'b0);
    repeat (5) tick();
    chk("vend_count", 64'(vend_seen), 64'(m_vends));
    chk("vend_count_sat", 64'(vend_seen_s), 64'(m_vends));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
